alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Keeps the ADD/SUB/AND/OR opcode encoding and carry-in semantics. Adds XOR, shifts, an iterative multiply, a zero/negative/overflow flag set, and valid/ready handshakes on both sides.
- Sits between the operand fetch stage and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 4).
- SHW, $clog2(WIDTH), derived; shift-amount width (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block accepts request this cycle
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (ADD) / borrow-in (SUB); ignored otherwise
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  low result
- result_hi  out  WIDTH  MUL high half; 0 for all other ops
- carry  out  1  carry/borrow flag
- zero  out  1  result == 0 (MUL: full 2*WIDTH product == 0)
- negative  out  1  result[WIDTH-1]
- overflow  out  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid, result, result_hi, carry, zero, negative, overflow all 0; in_ready 0 during reset. Reset mid-MUL aborts; no result is produced.
- Accept: in_valid & in_ready at a rising edge; operands are latched.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Back-to-back single-cycle ops run at 1 op/cycle when out_ready is held 1.
- Single-cycle ops (000-110): result registers load on the accept edge. out_valid rises the next cycle (latency 1).
- ADD: {carry,result} = a + b + cin.
- SUB: result = a - b - cin; carry = 1 iff borrow (a < b + cin, unsigned).
- overflow: ADD set when a, b same sign and result sign differs. SUB set when a, b differ in sign and result sign != a sign.
- AND/OR/XOR: bitwise; carry 0.
- SHL/SHR: logical, amount = b. If b >= WIDTH, result 0 and carry 0. Otherwise carry = last bit shifted out (0 when b==0).
- MUL: unsigned, shift-add, one partial product per cycle.
  - IDLE -> BUSY on accept; counter loads WIDTH-1.
  - BUSY decrements the counter; on count 0, {result_hi,result} are written and the FSM returns to IDLE with out_valid=1.
  - Latency WIDTH cycles from accept to out_valid; in_ready = 0 throughout BUSY.
  - carry = |result_hi; negative = result[WIDTH-1].
- States: IDLE, BUSY. Output-hold is tracked by out_valid, not by a separate state.
- Output hold: while out_valid & !out_ready, all outputs are stable and no new op is accepted.
- out_valid falls on out_ready unless a new single-cycle op is accepted on the same edge, in which case it stays 1 with new data.
- in_valid while !in_ready: ignored. No queueing; the requester must hold.
- Unused opcode semantics: none (all 8 codes defined).

Decomposition:
- Package alu_pkg: opcode enum (OP_ADD..OP_MUL), FSM state enum, flag struct {carry, zero, negative, overflow}.
- Sub-module alu_mul_seq: iterative multiplier. Ports: start, a, b, busy, done, product[2*WIDTH]. The top level holds the handshake, single-cycle datapath and flag logic.

Test Plan:
- WIDTH=8. ADD a=0xFF, b=0x01, cin=0 -> 1 cycle later out_valid; result 0x00, carry 1, zero 1, overflow 0.
- SUB a=0x80, b=0x01, cin=0 -> result 0x7F, carry 0, overflow 1, negative 0. SUB a=0x00, b=0x00, cin=1 -> result 0xFF, carry 1.
- MUL a=0xFF, b=0xFF -> in_ready low 8 cycles; out_valid exactly 8 cycles after accept; result 0x01, result_hi 0xFE, carry 1.
- Backpressure: SHL a=0x81, b=1 with out_ready=0 for 5 cycles -> result 0x02, carry 1 held stable; in_ready 0; a second request is not accepted until out_ready pulses.
- Streaming: 4 consecutive ops (AND, OR, XOR, SHR b=9) with out_ready=1 -> one result per cycle. The last result is 0 with carry 0.
- Reset: assert rst_n=0 during cycle 3 of MUL -> all outputs 0 immediately (async). After release, in_ready returns 1 and no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode and FSM encodings plus the flag bundle.
package alu_pkg;

    localparam int unsigned OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per op.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [PW-1:0]    acc_next;

    // Running sum including the partial product of the current multiplier bit
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start && !busy_q) begin
            acc_q    <= '0;
            mcand_q  <= PW'(a);
            mplier_q <= b;
            cnt_q    <= CW'(WIDTH - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // Final partial product is folded in combinationally so the top captures it on the last busy edge
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_next;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; single-cycle logic/arith/shift ops and an iterative MUL.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    alu_op_e            op_c;
    logic               accept_c;
    logic               is_mul_c;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    alu_flags_t         flags_q;

    logic [WIDTH-1:0]   res_c;
    alu_flags_t         flg_c;
    alu_flags_t         mul_flg_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [WIDTH:0]     shl_c;
    logic [WIDTH:0]     shr_c;
    logic               shamt_big_c;

    assign op_c     = alu_op_e'(opcode);
    assign is_mul_c = (op_c == OP_MUL);
    assign in_ready = rst_n && (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_c && is_mul_c),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c && is_mul_c) state_d = ST_BUSY;
            ST_BUSY: if (mul_done)             state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Carry/borrow and last-shifted-out bit fall out of one extra MSB/LSB on each path
    always_comb begin
        sum_c       = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        diff_c      = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        shl_c       = {1'b0, a} << b[SHW-1:0];
        shr_c       = {a, 1'b0} >> b[SHW-1:0];
        shamt_big_c = (b >= WIDTH'(WIDTH));
    end

    always_comb begin
        res_c = '0;
        flg_c = '0;
        case (op_c)
            OP_ADD: begin
                res_c          = sum_c[WIDTH-1:0];
                flg_c.carry    = sum_c[WIDTH];
                flg_c.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c          = diff_c[WIDTH-1:0];
                flg_c.carry    = diff_c[WIDTH];
                flg_c.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: res_c = a ^ b;
            OP_SHL: begin
                if (!shamt_big_c) begin
                    res_c       = shl_c[WIDTH-1:0];
                    flg_c.carry = shl_c[WIDTH];
                end
            end
            OP_SHR: begin
                if (!shamt_big_c) begin
                    res_c       = shr_c[WIDTH:1];
                    flg_c.carry = shr_c[0];
                end
            end
            default: res_c = '0;
        endcase
        flg_c.zero     = (res_c == '0);
        flg_c.negative = res_c[WIDTH-1];
    end

    always_comb begin
        mul_flg_c          = '0;
        mul_flg_c.carry    = |mul_product[2*WIDTH-1:WIDTH];
        mul_flg_c.zero     = (mul_product == '0);
        mul_flg_c.negative = mul_product[WIDTH-1];
    end

    // Output registers: a same-edge single-cycle accept keeps out_valid high with fresh data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else if (accept_c && !is_mul_c) begin
            out_valid_q <= 1'b1;
            result_q    <= res_c;
            result_hi_q <= '0;
            flags_q     <= flg_c;
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_product[WIDTH-1:0];
            result_hi_q <= mul_product[2*WIDTH-1:WIDTH];
            flags_q     <= mul_flg_c;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = flags_q.carry;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: directed plan cases, random traffic, mid-MUL reset.
module tb_alu_pipe;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [19:0]  sb[$];
    bit           rand_bp = 1'b0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {result_hi, result, carry, zero, negative, overflow}
    function automatic logic [19:0] model(input int op, input int av, input int bv, input int ci);
        int r, hi, c, v;
        logic z, n;
        r = 0; hi = 0; c = 0; v = 0;
        case (op)
            0: begin
                r = av + bv + ci;
                c = (r >> 8) & 1;
                r = r & 255;
                v = (((av >> 7) == (bv >> 7)) && (((r >> 7) & 1) != (av >> 7))) ? 1 : 0;
            end
            1: begin
                r = av - bv - ci;
                c = (av < bv + ci) ? 1 : 0;
                r = r & 255;
                v = (((av >> 7) != (bv >> 7)) && (((r >> 7) & 1) != (av >> 7))) ? 1 : 0;
            end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: if (bv < 8) begin
                r = (av << bv) & 255;
                c = (bv == 0) ? 0 : ((av >> (8 - bv)) & 1);
            end
            6: if (bv < 8) begin
                r = av >> bv;
                c = (bv == 0) ? 0 : ((av >> (bv - 1)) & 1);
            end
            default: begin
                r  = (av * bv) & 255;
                hi = (av * bv) >> 8;
                c  = (hi != 0) ? 1 : 0;
            end
        endcase
        z = (r == 0 && hi == 0);
        n = ((r >> 7) & 1) != 0;
        return {8'(hi), 8'(r), 1'(c), z, n, 1'(v)};
    endfunction

    // Call at posedge+#1; returns at posedge+#1 after the accept edge
    task automatic issue(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input bit expect_res, output int waits);
        waits    = 0;
        opcode   = op;
        a        = av;
        b        = bv;
        cin      = ci;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 60) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("issue_timeout", 64'(1), 64'(0));
            in_valid = 1'b0;
            return;
        end
        if (expect_res) sb.push_back(model(int'(op), int'(av), int'(bv), int'(ci)));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: a result is consumed on the edge following a valid&ready sample
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'(1), 64'(0));
            end else begin
                check("result", 64'({result_hi, result, carry, zero, negative, overflow}),
                      64'(sb.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        #12;
        check("reset_outputs", 64'({in_ready, out_valid, result, result_hi, carry, zero, negative, overflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(in_ready), 64'(1));

        // Arithmetic corner cases, back to back
        out_ready = 1'b1;
        issue(3'b000, 8'hFF, 8'h01, 1'b0, 1'b1, w);
        check("add_latency", 64'(out_valid), 64'(1));
        issue(3'b001, 8'h80, 8'h01, 1'b0, 1'b1, w);
        issue(3'b001, 8'h00, 8'h00, 1'b1, 1'b1, w);
        check("sub_b2b_stall", 64'(w), 64'(0));

        // MUL latency and in_ready low throughout
        issue(3'b111, 8'hFF, 8'hFF, 1'b0, 1'b1, w);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            check("mul_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
            cnt++;
        end
        check("mul_latency", 64'(cnt), 64'(8));
        @(posedge clk);
        #1;

        // Backpressure hold with a competing request
        out_ready = 1'b0;
        issue(3'b101, 8'h81, 8'h01, 1'b0, 1'b1, w);
        opcode   = 3'b000;
        a        = 8'h01;
        b        = 8'h02;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_result", 64'(result), 64'(8'h02));
            check("bp_carry", 64'(carry), 64'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'(1));
        sb.push_back(model(0, 1, 2, 0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;

        // Streaming one op per cycle
        issue(3'b010, 8'hF0, 8'h3C, 1'b0, 1'b1, w);
        issue(3'b011, 8'h0F, 8'h30, 1'b0, 1'b1, w);
        check("stream_or_stall", 64'(w), 64'(0));
        issue(3'b100, 8'hAA, 8'hFF, 1'b0, 1'b1, w);
        check("stream_xor_stall", 64'(w), 64'(0));
        issue(3'b110, 8'hFF, 8'h09, 1'b0, 1'b1, w);
        check("stream_shr_stall", 64'(w), 64'(0));
        check("stream_valid", 64'(out_valid), 64'(1));

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [7:0] bv;
            op = 3'($urandom_range(0, 7));
            bv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            issue(op, 8'($urandom), bv, 1'($urandom_range(0, 1)), 1'b1, w);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cnt = 0;
        while (sb.size() != 0 && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("drain", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;

        // Reset during the third MUL cycle aborts without a result
        issue(3'b111, 8'h12, 8'h34, 1'b0, 1'b0, w);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midmul_reset_outputs", 64'({in_ready, out_valid, result, result_hi, carry, zero, negative, overflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midmul_ready_after", 64'(in_ready), 64'(1));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midmul_no_stale", 64'(out_valid), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
